// File: rtl/tmb_fiber_in_deframer.sv
// Receive-side deframer for the TMB trigger fiber link: aligns HI/SEP word pairs,
// rebuilds the 48-bit payload and reports lock, idle, errors and the 50FC latency marker.
// Optional saturating framing-error counter is built only when TMB_FIBER_ERR_CNT_EN is defined.
module tmb_fiber_in_deframer #(
    parameter int unsigned LOCK_PAIRS = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             TRG_CLK80,
    input  logic             TRG_RST_N,
    input  logic             TRG_RX_VALID,
    input  logic [31:0]      TRG_RX_DATA,
    input  logic [3:0]       TRG_RX_ISK,
    output logic [47:0]      RX_DATA,
    output logic             RX_DATA_VALID,
    output logic             LOCKED,
    output logic             RX_IDLE,
    output logic             LTNCY_DET,
    output logic             FRM_ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        Hunt,
        ExpHi,
        ExpSep
    } state_t;

    localparam logic [3:0] LockTarget = 4'(LOCK_PAIRS);
    localparam logic [15:0] MarkNorm  = 16'h50BC;
    localparam logic [15:0] MarkLtncy = 16'h50FC;

    state_t      state;
    logic [3:0]  good_cnt;
    logic [31:0] hi_reg;

    logic        is_idle;
    logic        is_sep;
    logic        is_hi;
    logic        err_now;
    logic        frame_done;
    logic [3:0]  good_inc;

    // Word classification of the current input word.
    always_comb begin
        is_idle = (TRG_RX_DATA == 32'h50BC50BC) && (TRG_RX_ISK == 4'b0101);
        is_sep  = (TRG_RX_ISK == 4'b0001) &&
                  ((TRG_RX_DATA[15:0] == MarkNorm) || (TRG_RX_DATA[15:0] == MarkLtncy));
        is_hi   = (TRG_RX_ISK == 4'b0000);
    end

    // Framing violations are only meaningful once aligned; IDLE is always tolerated.
    always_comb begin
        err_now    = 1'b0;
        frame_done = 1'b0;
        if (TRG_RX_VALID) begin
            unique case (state)
                ExpHi:   err_now = !is_hi && !is_idle;
                ExpSep: begin
                    err_now    = !is_sep && !is_idle;
                    frame_done = is_sep;
                end
                default: err_now = 1'b0;
            endcase
        end
        good_inc = (good_cnt == LockTarget) ? good_cnt : good_cnt + 4'd1;
    end

    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            state         <= Hunt;
            good_cnt      <= 4'd0;
            hi_reg        <= 32'd0;
            RX_DATA       <= 48'd0;
            RX_DATA_VALID <= 1'b0;
            LOCKED        <= 1'b0;
            RX_IDLE       <= 1'b0;
            LTNCY_DET     <= 1'b0;
            FRM_ERR       <= 1'b0;
        end else begin
            RX_DATA_VALID <= 1'b0;
            LTNCY_DET     <= 1'b0;
            FRM_ERR       <= 1'b0;
            RX_IDLE       <= TRG_RX_VALID && is_idle;
            // Tracks the registered count, so a cleared count drops LOCKED one cycle after FRM_ERR.
            LOCKED        <= (good_cnt == LockTarget);

            if (!TRG_RX_VALID) begin
                state    <= Hunt;
                good_cnt <= 4'd0;
                LOCKED   <= 1'b0;
            end else if (err_now) begin
                state    <= Hunt;
                good_cnt <= 4'd0;
                FRM_ERR  <= 1'b1;
            end else begin
                unique case (state)
                    Hunt: begin
                        if (is_sep || is_idle) begin
                            state <= ExpHi;
                        end
                    end
                    ExpHi: begin
                        if (is_hi) begin
                            hi_reg <= TRG_RX_DATA;
                            state  <= ExpSep;
                        end
                    end
                    ExpSep: begin
                        // Only SEP or IDLE reach here; IDLE discards the partial frame.
                        state <= ExpHi;
                        if (frame_done) begin
                            RX_DATA       <= {hi_reg, TRG_RX_DATA[31:16]};
                            RX_DATA_VALID <= 1'b1;
                            LTNCY_DET     <= (TRG_RX_DATA[15:0] == MarkLtncy);
                            good_cnt      <= good_inc;
                            LOCKED        <= (good_inc == LockTarget);
                        end
                    end
                    default: state <= Hunt;
                endcase
            end
        end
    end

`ifdef TMB_FIBER_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            err_cnt <= '0;
        end else if (err_now && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign ERR_CNT = err_cnt;
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_tmb_fiber_in_deframer.sv
// Self-checking bench for tmb_fiber_in_deframer: directed scenarios then randomized word
// streams, all checked against a queue-based frame model built from the word-class rules.
module tb_tmb_fiber_in_deframer;

    localparam int LP = 4;
    localparam int CW = 4;
    localparam int C_IDLE = 0, C_SEP = 1, C_HI = 2, C_BAD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld = 1'b0;
    logic [31:0]   data = 32'd0;
    logic [3:0]    isk = 4'd0;
    logic [47:0]   rx_data;
    logic          rx_valid;
    logic          locked;
    logic          rx_idle;
    logic          ltncy;
    logic          frm_err;
    logic [CW-1:0] err_cnt;

    tmb_fiber_in_deframer #(
        .LOCK_PAIRS (LP),
        .CNT_W      (CW)
    ) dut (
        .TRG_CLK80     (clk),
        .TRG_RST_N     (rst_n),
        .TRG_RX_VALID  (vld),
        .TRG_RX_DATA   (data),
        .TRG_RX_ISK    (isk),
        .RX_DATA       (rx_data),
        .RX_DATA_VALID (rx_valid),
        .LOCKED        (locked),
        .RX_IDLE       (rx_idle),
        .LTNCY_DET     (ltncy),
        .FRM_ERR       (frm_err),
        .ERR_CNT       (err_cnt)
    );

    always #6 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: aligned flag, one-entry queue holding a captured HI word.
    bit          m_sync = 0;
    logic [31:0] m_pend[$];
    int          m_good = 0;
    int          m_errs = 0;
    logic [47:0] e_data = 48'd0;
    bit          e_valid, e_lt, e_err, e_lock, e_idle;

    function automatic int classify(logic [31:0] d, logic [3:0] k);
        if (d == 32'h50BC50BC && k == 4'b0101) return C_IDLE;
        if (k == 4'b0001 && (d[15:0] == 16'h50BC || d[15:0] == 16'h50FC)) return C_SEP;
        if (k == 4'b0000) return C_HI;
        return C_BAD;
    endfunction

    function automatic int exp_err_cnt();
`ifdef TMB_FIBER_ERR_CNT_EN
        return (m_errs > (2 ** CW) - 1) ? (2 ** CW) - 1 : m_errs;
`else
        return 0;
`endif
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(bit v, logic [31:0] d, logic [3:0] k);
        int  c = classify(d, k);
        int  good_before = m_good;
        bit  frame = 0;
        bit  err = 0;
        e_valid = 0;
        e_lt    = 0;
        e_err   = 0;
        e_idle  = v && (c == C_IDLE);
        if (!v) begin
            m_sync = 0;
            m_pend.delete();
            m_good = 0;
        end else if (!m_sync) begin
            if (c == C_SEP || c == C_IDLE) m_sync = 1;
        end else if (m_pend.size() == 0) begin
            if (c == C_HI) m_pend.push_back(d);
            else if (c != C_IDLE) err = 1;
        end else begin
            if (c == C_SEP) frame = 1;
            else if (c == C_IDLE) m_pend.delete();
            else err = 1;
        end
        if (frame) begin
            e_data  = {m_pend.pop_front(), d[31:16]};
            e_valid = 1;
            e_lt    = (d[15:0] == 16'h50FC);
            if (m_good < LP) m_good++;
        end
        if (err) begin
            e_err  = 1;
            m_sync = 0;
            m_pend.delete();
            m_good = 0;
            m_errs++;
        end
        if (!v) e_lock = 0;
        else if (frame) e_lock = (m_good == LP);
        else e_lock = (good_before == LP);
    endtask

    task automatic step(bit v, logic [31:0] d, logic [3:0] k);
        vld  = v;
        data = d;
        isk  = k;
        model(v, d, k);
        @(posedge clk);
        #1;
        check("rx_data_valid", rx_valid, e_valid);
        check("rx_data", rx_data, e_data);
        check("ltncy_det", ltncy, e_lt);
        check("frm_err", frm_err, e_err);
        check("locked", locked, e_lock);
        if (v) check("rx_idle", rx_idle, e_idle);
        check("err_cnt", err_cnt, exp_err_cnt());
    endtask

    task automatic idle_w();
        step(1, 32'h50BC50BC, 4'b0101);
    endtask

    task automatic hi_w(logic [31:0] d);
        step(1, d, 4'b0000);
    endtask

    task automatic sep_w(logic [15:0] lo, bit mark);
        step(1, {lo, (mark ? 16'h50FC : 16'h50BC)}, 4'b0001);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", rx_data, 48'd0);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_idle", rx_idle, 1'b0);
        check("rst_ltncy", ltncy, 1'b0);
        check("rst_err", frm_err, 1'b0);
        check("rst_errcnt", err_cnt, '0);
        rst_n = 1'b1;

        // First frame after idle stream
        repeat (3) idle_w();
        hi_w(32'hA5A5_1234);
        sep_w(16'h5678, 0);
        check("tp1_data", rx_data, 48'hA5A5_1234_5678);
        check("tp1_valid", rx_valid, 1'b1);
        check("tp1_ltncy", ltncy, 1'b0);

        // Lock on the 4th frame, latency marker on the 5th
        for (int i = 0; i < 3; i++) begin
            check("prelock", locked, 1'b0);
            hi_w($urandom);
            sep_w(16'($urandom), 0);
        end
        check("tp2_locked", locked, 1'b1);
        hi_w(32'h0BAD_F00D);
        sep_w(16'hCAFE, 1);
        check("tp2_ltncy", ltncy, 1'b1);

        // HI where SEP expected while locked
        hi_w(32'h1111_2222);
        hi_w(32'h3333_4444);
        check("tp3_err", frm_err, 1'b1);
        check("tp3_locked_hold", locked, 1'b1);
        idle_w();
        check("tp3_locked_drop", locked, 1'b0);
        for (int i = 0; i < 4; i++) begin
            hi_w($urandom);
            sep_w(16'($urandom), 0);
        end
        check("tp3_relock", locked, 1'b1);

        // Transmitter reset mid-frame
        hi_w(32'h5555_6666);
        idle_w();
        check("tp4_noerr", frm_err, 1'b0);
        check("tp4_novalid", rx_valid, 1'b0);
        check("tp4_idle", rx_idle, 1'b1);
        check("tp4_locked", locked, 1'b1);
        hi_w(32'h7777_8888);
        sep_w(16'h9999, 0);
        check("tp4_data", rx_data, 48'h7777_8888_9999);

        // TRG_RX_VALID dropped mid-frame
        hi_w(32'hDEAD_BEEF);
        repeat (3) step(0, $urandom, 4'($urandom_range(0, 15)));
        check("tp5_locked", locked, 1'b0);
        sep_w(16'h1234, 0);
        check("tp5_first_sep", rx_valid, 1'b0);
        hi_w(32'hFEED_FACE);
        sep_w(16'h4321, 0);
        check("tp5_data", rx_data, 48'hFEED_FACE_4321);

        // 20 framing errors to exercise counter saturation
        for (int i = 0; i < 20; i++) begin
            idle_w();
            step(1, $urandom, 4'b1000);
        end
        check("tp6_errcnt", err_cnt, CW'(exp_err_cnt()));

        // Randomized word stream
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 3) step(0, $urandom, 4'($urandom_range(0, 15)));
            else if (r < 20) idle_w();
            else if (r < 75) begin
                hi_w($urandom);
                sep_w(16'($urandom), $urandom_range(0, 1) == 1);
            end
            else if (r < 85) hi_w($urandom);
            else if (r < 93) sep_w(16'($urandom), $urandom_range(0, 1) == 1);
            else step(1, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tmb_fiber_in_deframer.md
Name: tmb_fiber_in_deframer

Overview:
- Receive-side deframer for the TMB trigger fiber link.
- Consumes the 32-bit/4-bit-charisk word stream from the GTX receiver at 80 MHz.
- Locates the two-word frame (payload-high word, then separator word carrying the low payload half and K28.5 marker), and reassembles the 48-bit comparator payload.
- Reports lock, idle, frame errors and the latency marker (50FC) for latency measurement against the transmitter's LTNCY_TRIG.

Parameters:
- LOCK_PAIRS, 4: consecutive good frames required before LOCKED asserts (1..15).
- CNT_W, 16: width of the optional error counter.

Ports:
- TRG_CLK80  in  1  80 MHz receive user clock (RXUSRCLK2 domain).
- TRG_RST_N  in  1  asynchronous active-low reset.
- TRG_RX_VALID  in  1  high when GTX RX reset done and byte-aligned.
- TRG_RX_DATA  in  32  received data word.
- TRG_RX_ISK  in  4  per-byte K-character flags.
- RX_DATA  out  48  reassembled payload {G6C..G1C}.
- RX_DATA_VALID  out  1  one-cycle strobe, RX_DATA valid.
- LOCKED  out  1  frame lock achieved.
- RX_IDLE  out  1  last word received was idle.
- LTNCY_DET  out  1  one-cycle strobe, frame carried 50FC marker.
- FRM_ERR  out  1  one-cycle strobe, framing violation.
- ERR_CNT  out  CNT_W  saturating framing-error count (only with feature).

Behaviour:
- Word classes, decoded combinationally from the current input word:
  - IDLE: data 32'h50BC50BC, isk 4'b0101.
  - SEP: isk 4'b0001, and data[15:0] equals 16'h50BC or 16'h50FC.
  - HI: isk 4'b0000.
  - BAD: anything else.
- Reset (TRG_RST_N low, asynchronous): state HUNT, good_cnt 0, hi_reg 0, all outputs 0, RX_DATA 0.
- TRG_RX_VALID low in any state:
  - Next state HUNT, good_cnt cleared, LOCKED 0.
  - No FRM_ERR.
  - Has priority over every other event.
- FSM states: HUNT, EXP_HI, EXP_SEP.
  - HUNT:
    - SEP or IDLE -> EXP_HI.
    - Else stay.
    - No errors flagged while in HUNT.
  - EXP_HI:
    - HI -> capture hi_reg <= data; go to EXP_SEP.
    - IDLE -> stay, no error.
    - SEP or BAD -> FRM_ERR, HUNT.
  - EXP_SEP:
    - SEP -> frame complete; go to EXP_HI.
    - IDLE -> EXP_HI, partial frame discarded, no error (covers transmitter reset mid-frame).
    - HI or BAD -> FRM_ERR, HUNT.
- Frame complete, with outputs registered one cycle after the SEP word is sampled:
  - RX_DATA <= {hi_reg, data[31:16]}.
  - RX_DATA_VALID = 1.
  - LTNCY_DET = 1 if data[15:0] == 16'h50FC.
- Latency is 1 TRG_CLK80 cycle from the SEP input to the strobe.
- RX_DATA holds its value between strobes.
- good_cnt:
  - Increments on each complete frame and saturates at LOCK_PAIRS.
  - Cleared on FRM_ERR or on entry to HUNT.
  - IDLE words do not clear it.
- LOCKED is registered and equals (good_cnt == LOCK_PAIRS). It asserts in the same cycle as the RX_DATA_VALID of the LOCK_PAIRS-th frame and drops the cycle after the FRM_ERR strobe.
- RX_DATA_VALID fires for every complete frame regardless of LOCKED; downstream qualifies with LOCKED.
- RX_IDLE: registered, 1 while the most recently sampled word is IDLE.
- FRM_ERR, RX_DATA_VALID and LTNCY_DET are never asserted in the same cycle as a HUNT entry caused by TRG_RX_VALID low.

Optional Feature:
- Macro: TMB_FIBER_ERR_CNT_EN.
- Defined:
  - ERR_CNT increments on each FRM_ERR and saturates at all-ones (no wrap).
  - Cleared only by reset.
  - Unaffected by TRG_RX_VALID.
- Undefined: ERR_CNT is driven constant 0 and the counter logic is not built.

Test Plan:
- Reset then valid; stream of IDLE, then HI 32'hA5A5_1234, SEP 32'h5678_50BC -> next cycle RX_DATA = 48'hA5A51234_5678, RX_DATA_VALID one cycle, LTNCY_DET 0.
- 4 clean HI/SEP frames -> LOCKED rises with the 4th RX_DATA_VALID. 5th frame's SEP has low half 16'h50FC -> LTNCY_DET pulses with its RX_DATA_VALID.
- While locked, inject HI where SEP expected -> FRM_ERR one cycle, LOCKED drops next cycle, ERR_CNT = 1 (feature on). Relock requires 4 further good frames.
- HI followed by IDLE (transmitter reset mid-frame) -> no FRM_ERR, no RX_DATA_VALID, RX_IDLE 1. LOCKED stays 1. Next HI/SEP is decoded normally.
- Drop TRG_RX_VALID for 3 cycles mid-frame -> LOCKED 0, no FRM_ERR, state HUNT. The first SEP after valid returns causes no output; the following HI/SEP pair outputs.
- Feature on: force CNT_W = 4 and inject 20 errors -> ERR_CNT saturates at 4'hF. Feature off -> ERR_CNT stays 0.
